// File: rtl/ll_data_table_delete.sv
// Delete engine for the linked-list hash table: walks a bucket chain in data RAM,
// unlinks the matching node, clears it and hands its address back to the free list.
module ll_data_table_delete #(
  parameter int RAM_LATENCY = 2,
  parameter int A_WIDTH     = 8,
  parameter int KEY_WIDTH   = 8,
  localparam int D_W        = KEY_WIDTH + A_WIDTH + 1,
  localparam int R_W        = KEY_WIDTH + 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  // task_i = {cmd.key, head_ptr, head_ptr_val}
  input  logic [D_W-1:0]     task_i,
  input  logic               task_valid_i,
  output logic               task_ready_o,
  // RAM word = {key, next_ptr, next_ptr_val}
  input  logic [D_W-1:0]     rd_data_i,
  output logic [A_WIDTH-1:0] rd_addr_o,
  output logic               rd_en_o,
  output logic [A_WIDTH-1:0] wr_addr_o,
  output logic [D_W-1:0]     wr_data_o,
  output logic               wr_en_o,
  output logic [A_WIDTH-1:0] empty_addr_o,
  output logic               empty_addr_add_o,
  output logic [A_WIDTH-1:0] head_wr_data_ptr_o,
  output logic               head_wr_data_ptr_val_o,
  output logic               head_wr_en_o,
  // result_o = {cmd.key, rescode[1:0], chain_state[1:0]}
  output logic [R_W-1:0]     result_o,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [2:0]         o_dbg_state
);

  // Handshakes: a transfer happens on a rising clk_i edge where valid and ready are
  // both high; a producer holds valid and its payload stable until that edge.

  localparam logic [1:0] LL_DELETE_SUCCESS              = 2'd0;
  localparam logic [1:0] LL_DELETE_NOT_SUCCESS_NO_ENTRY = 2'd1;
  localparam logic [1:0] LL_NO_CHAIN  = 2'd0;
  localparam logic [1:0] LL_IN_HEAD   = 2'd1;
  localparam logic [1:0] LL_IN_MIDDLE = 2'd2;
  localparam logic [1:0] LL_IN_TAIL   = 2'd3;

  typedef enum logic [2:0] {
    IDLE_S        = 3'd0,
    READ_HEAD_S   = 3'd1,
    GO_ON_CHAIN_S = 3'd2,
    HEAD_MATCH_S  = 3'd3,
    LINK_MATCH_S  = 3'd4,
    CLEAR_S       = 3'd5,
    NOT_FOUND_S   = 3'd6
  } state_t;

  state_t                 r_state;
  logic [KEY_WIDTH-1:0]   r_key;
  logic [A_WIDTH-1:0]     r_rd_addr;
  logic [A_WIDTH-1:0]     r_prev_addr;
  logic [KEY_WIDTH-1:0]   r_prev_key;
  logic [A_WIDTH-1:0]     r_match_next_ptr;
  logic                   r_match_next_val;
  logic                   r_rd_en;
  logic [RAM_LATENCY-1:0] r_rd_pipe;
  logic                   r_wr_en;
  logic [A_WIDTH-1:0]     r_wr_addr;
  logic [D_W-1:0]         r_wr_data;
  logic                   r_empty_add;
  logic                   r_head_wr_en;
  logic                   r_result_valid;
  logic [1:0]             r_rescode;
  logic [1:0]             r_chain;

  logic [KEY_WIDTH-1:0] w_task_key;
  logic [A_WIDTH-1:0]   w_task_head_ptr;
  logic                 w_task_head_val;
  logic [KEY_WIDTH-1:0] w_rd_key;
  logic [A_WIDTH-1:0]   w_rd_next_ptr;
  logic                 w_rd_next_val;
  logic                 w_rd_valid;

  assign w_task_key      = task_i[D_W-1 -: KEY_WIDTH];
  assign w_task_head_ptr = task_i[A_WIDTH:1];
  assign w_task_head_val = task_i[0];
  assign w_rd_key        = rd_data_i[D_W-1 -: KEY_WIDTH];
  assign w_rd_next_ptr   = rd_data_i[A_WIDTH:1];
  assign w_rd_next_val   = rd_data_i[0];
  // Read data is trusted only in the cycle the strobe pipe says it lands.
  assign w_rd_valid      = r_rd_pipe[RAM_LATENCY-1];

  assign task_ready_o           = (r_state == IDLE_S);
  assign rd_addr_o              = r_rd_addr;
  assign rd_en_o                = r_rd_en;
  assign wr_addr_o              = r_wr_addr;
  assign wr_data_o              = r_wr_data;
  assign wr_en_o                = r_wr_en;
  assign empty_addr_o           = r_rd_addr;
  assign empty_addr_add_o       = r_empty_add;
  assign head_wr_data_ptr_o     = r_match_next_ptr;
  assign head_wr_data_ptr_val_o = r_match_next_val;
  assign head_wr_en_o           = r_head_wr_en;
  assign result_o               = {r_key, r_rescode, r_chain};
  assign result_valid_o         = r_result_valid;
  assign o_dbg_state            = r_state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state          <= IDLE_S;
      r_key            <= '0;
      r_rd_addr        <= '0;
      r_prev_addr      <= '0;
      r_prev_key       <= '0;
      r_match_next_ptr <= '0;
      r_match_next_val <= 1'b0;
      r_rd_en          <= 1'b0;
      r_rd_pipe        <= '0;
      r_wr_en          <= 1'b0;
      r_wr_addr        <= '0;
      r_wr_data        <= '0;
      r_empty_add      <= 1'b0;
      r_head_wr_en     <= 1'b0;
      r_result_valid   <= 1'b0;
      r_rescode        <= '0;
      r_chain          <= '0;
    end else begin
      // Strobes are one-cycle pulses unless a transition below re-arms them.
      r_rd_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_empty_add  <= 1'b0;
      r_head_wr_en <= 1'b0;
      r_rd_pipe[0] <= r_rd_en;
      for (int i = 1; i < RAM_LATENCY; i++) r_rd_pipe[i] <= r_rd_pipe[i-1];

      case (r_state)
        IDLE_S: begin
          if (task_valid_i) begin
            r_key <= w_task_key;
            if (!w_task_head_val) begin
              r_state        <= NOT_FOUND_S;
              r_result_valid <= 1'b1;
              r_rescode      <= LL_DELETE_NOT_SUCCESS_NO_ENTRY;
              r_chain        <= LL_NO_CHAIN;
            end else begin
              r_rd_addr <= w_task_head_ptr;
              r_rd_en   <= 1'b1;
              r_state   <= READ_HEAD_S;
            end
          end
        end

        READ_HEAD_S, GO_ON_CHAIN_S: begin
          if (w_rd_valid) begin
            if (w_rd_key == r_key) begin
              r_match_next_ptr <= w_rd_next_ptr;
              r_match_next_val <= w_rd_next_val;
              if (r_state == READ_HEAD_S) begin
                r_head_wr_en <= 1'b1;
                r_chain      <= LL_IN_HEAD;
                r_state      <= HEAD_MATCH_S;
              end else begin
                // Predecessor keeps its key but inherits the victim's link.
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_prev_addr;
                r_wr_data <= {r_prev_key, w_rd_next_ptr, w_rd_next_val};
                r_chain   <= w_rd_next_val ? LL_IN_MIDDLE : LL_IN_TAIL;
                r_state   <= LINK_MATCH_S;
              end
            end else if (!w_rd_next_val) begin
              r_state        <= NOT_FOUND_S;
              r_result_valid <= 1'b1;
              r_rescode      <= LL_DELETE_NOT_SUCCESS_NO_ENTRY;
              r_chain        <= LL_NO_CHAIN;
            end else begin
              r_prev_addr <= r_rd_addr;
              r_prev_key  <= w_rd_key;
              r_rd_addr   <= w_rd_next_ptr;
              r_rd_en     <= 1'b1;
              r_state     <= GO_ON_CHAIN_S;
            end
          end
        end

        HEAD_MATCH_S, LINK_MATCH_S: begin
          r_wr_en        <= 1'b1;
          r_wr_addr      <= r_rd_addr;
          r_wr_data      <= '0;
          r_empty_add    <= 1'b1;
          r_result_valid <= 1'b1;
          r_rescode      <= LL_DELETE_SUCCESS;
          r_state        <= CLEAR_S;
        end

        CLEAR_S, NOT_FOUND_S: begin
          if (result_ready_i) begin
            r_result_valid <= 1'b0;
            r_state        <= IDLE_S;
          end
        end

        default: r_state <= IDLE_S;
      endcase
    end
  end

endmodule

// File: tb/tb_ll_data_table_delete.sv
// Directed bench for ll_data_table_delete: a latency-2 RAM model, a strobe monitor
// and a linear sequence of delete scenarios checked against hand-computed values.
module tb_ll_data_table_delete;

  localparam int AW  = 8;
  localparam int KW  = 8;
  localparam int DW  = KW + AW + 1;
  localparam int RW  = KW + 4;
  localparam int REC = AW + DW;

  logic          clk_i;
  logic          rst_i;
  logic [DW-1:0] task_i;
  logic          task_valid_i;
  logic          task_ready_o;
  logic [DW-1:0] rd_data_i;
  logic [AW-1:0] rd_addr_o;
  logic          rd_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic          wr_en_o;
  logic [AW-1:0] empty_addr_o;
  logic          empty_addr_add_o;
  logic [AW-1:0] head_wr_data_ptr_o;
  logic          head_wr_data_ptr_val_o;
  logic          head_wr_en_o;
  logic [RW-1:0] result_o;
  logic          result_valid_o;
  logic          result_ready_i;
  logic [2:0]    o_dbg_state;

  ll_data_table_delete #(.RAM_LATENCY(2), .A_WIDTH(AW), .KEY_WIDTH(KW)) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .task_i                 (task_i),
    .task_valid_i           (task_valid_i),
    .task_ready_o           (task_ready_o),
    .rd_data_i              (rd_data_i),
    .rd_addr_o              (rd_addr_o),
    .rd_en_o                (rd_en_o),
    .wr_addr_o              (wr_addr_o),
    .wr_data_o              (wr_data_o),
    .wr_en_o                (wr_en_o),
    .empty_addr_o           (empty_addr_o),
    .empty_addr_add_o       (empty_addr_add_o),
    .head_wr_data_ptr_o     (head_wr_data_ptr_o),
    .head_wr_data_ptr_val_o (head_wr_data_ptr_val_o),
    .head_wr_en_o           (head_wr_en_o),
    .result_o               (result_o),
    .result_valid_o         (result_valid_o),
    .result_ready_i         (result_ready_i),
    .o_dbg_state            (o_dbg_state)
  );

  // ---------------- clock ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- RAM model (2-cycle read latency) ----------------
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rd_p1, rd_p2;
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk_i) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (wr_en_o) mem[wr_addr_o] <= wr_data_o;
    rd_p1 <= rd_en_o ? mem[rd_addr_o] : {DW{1'b1}};
    rd_p2 <= rd_p1;
  end
  assign rd_data_i = rd_p2;

  // ---------------- strobe monitor ----------------
  int            cnt_rd, cnt_wr, cnt_push, cnt_head, cnt_ovl;
  logic [REC-1:0] wr_log [0:63];
  logic [AW-1:0] last_push;
  logic [AW:0]   last_head;

  initial begin
    cnt_rd = 0; cnt_wr = 0; cnt_push = 0; cnt_head = 0; cnt_ovl = 0;
    last_push = '0; last_head = '0;
  end

  always @(negedge clk_i) begin
    if (rd_en_o) cnt_rd <= cnt_rd + 1;
    if (wr_en_o) begin
      wr_log[cnt_wr % 64] <= {wr_addr_o, wr_data_o};
      cnt_wr <= cnt_wr + 1;
      if (rd_en_o) cnt_ovl <= cnt_ovl + 1;
    end
    if (empty_addr_add_o) begin
      cnt_push  <= cnt_push + 1;
      last_push <= empty_addr_o;
    end
    if (head_wr_en_o) begin
      cnt_head  <= cnt_head + 1;
      last_head <= {head_wr_data_ptr_o, head_wr_data_ptr_val_o};
    end
  end

  // ---------------- scoreboard ----------------
  int              n_total, n_bad;
  logic [REC-1:0]  exp_q[$];
  int              b_rd, b_wr, b_push, b_head, b_ovl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    #1;
    b_rd = cnt_rd; b_wr = cnt_wr; b_push = cnt_push; b_head = cnt_head; b_ovl = cnt_ovl;
    exp_q.delete();
  endtask

  task automatic check_writes(input string tag);
    int n;
    #1;
    n = cnt_wr - b_wr;
    check({tag, "_wr_count"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check({tag, "_wr_rec"}, wr_log[(b_wr + i) % 64], exp_q[i]);
    check({tag, "_wr_rd_overlap"}, cnt_ovl - b_ovl, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [AW-1:0] a, input logic [KW-1:0] k,
                         input logic [AW-1:0] np, input logic nv);
    @(negedge clk_i);
    pl_en = 1'b1; pl_addr = a; pl_data = {k, np, nv};
    @(negedge clk_i);
    pl_en = 1'b0;
  endtask

  task automatic load_chain();
    preload(8'd5, 8'hA1, 8'd9, 1'b1);
    preload(8'd9, 8'hB2, 8'd2, 1'b1);
    preload(8'd2, 8'hC3, 8'd0, 1'b0);
  endtask

  // Issues a task and counts negedges after the accept edge until result_valid_o.
  task automatic run_task(input logic [KW-1:0] k, input logic [AW-1:0] hp, input logic hv,
                          output int lat);
    @(negedge clk_i);
    check("task_ready_idle", task_ready_o, 1'b1);
    task_i = {k, hp, hv};
    task_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    task_valid_i = 1'b0;
    lat = 1;
    while (!result_valid_o && lat < 200) begin
      @(negedge clk_i);
      lat++;
    end
    check("result_valid_seen", result_valid_o, 1'b1);
  endtask

  task automatic finish_result();
    result_ready_i = 1'b1;
    @(negedge clk_i);
    result_ready_i = 1'b0;
    check("result_valid_drop", result_valid_o, 1'b0);
    check("task_ready_back", task_ready_o, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  int lat;
  int guard;

  initial begin
    n_total = 0; n_bad = 0;
    rst_i = 1'b1; task_i = '0; task_valid_i = 1'b0; result_ready_i = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(negedge clk_i);

    // reset state
    check("rst_state", o_dbg_state, 3'd0);
    check("rst_task_ready", task_ready_o, 1'b1);
    check("rst_result_valid", result_valid_o, 1'b0);
    check("rst_strobes", {rd_en_o, wr_en_o, empty_addr_add_o, head_wr_en_o}, 4'b0);
    rst_i = 1'b0;

    // empty bucket
    mark();
    run_task(8'h11, 8'd0, 1'b0, lat);
    check("empty_latency", lat, 1);
    check("empty_result", result_o, {8'h11, 2'd1, 2'd0});
    finish_result();
    check_writes("empty");
    check("empty_reads", cnt_rd - b_rd, 0);
    check("empty_push", cnt_push - b_push, 0);
    check("empty_head", cnt_head - b_head, 0);

    // single-node chain, head match
    preload(8'd5, 8'h11, 8'd0, 1'b0);
    mark();
    exp_q.push_back({8'd5, 17'd0});
    run_task(8'h11, 8'd5, 1'b1, lat);
    check("single_latency", lat, 5);
    check("single_result", result_o, {8'h11, 2'd0, 2'd1});
    finish_result();
    check_writes("single");
    check("single_head_cnt", cnt_head - b_head, 1);
    check("single_head_val", last_head, {8'd0, 1'b0});
    check("single_push_cnt", cnt_push - b_push, 1);
    check("single_push_addr", last_push, 8'd5);

    // chain 5->9->2, delete middle
    load_chain();
    mark();
    exp_q.push_back({8'd5, 8'hA1, 8'd2, 1'b1});
    exp_q.push_back({8'd9, 17'd0});
    run_task(8'hB2, 8'd5, 1'b1, lat);
    check("mid_latency", lat, 8);
    check("mid_result", result_o, {8'hB2, 2'd0, 2'd2});
    finish_result();
    check_writes("mid");
    check("mid_push_cnt", cnt_push - b_push, 1);
    check("mid_push_addr", last_push, 8'd9);
    check("mid_head_cnt", cnt_head - b_head, 0);

    // chain 5->9->2, delete tail
    load_chain();
    mark();
    exp_q.push_back({8'd9, 8'hB2, 8'd0, 1'b0});
    exp_q.push_back({8'd2, 17'd0});
    run_task(8'hC3, 8'd5, 1'b1, lat);
    check("tail_latency", lat, 11);
    check("tail_result", result_o, {8'hC3, 2'd0, 2'd3});
    finish_result();
    check_writes("tail");
    check("tail_reads", cnt_rd - b_rd, 3);
    check("tail_push_addr", last_push, 8'd2);

    // chain 5->9->2, key absent
    load_chain();
    mark();
    run_task(8'hD4, 8'd5, 1'b1, lat);
    check("miss_latency", lat, 10);
    check("miss_result", result_o, {8'hD4, 2'd1, 2'd0});
    finish_result();
    check_writes("miss");
    check("miss_reads", cnt_rd - b_rd, 3);
    check("miss_push", cnt_push - b_push, 0);
    check("miss_head", cnt_head - b_head, 0);

    // result back-pressure for 10 cycles
    preload(8'd5, 8'h11, 8'd0, 1'b0);
    mark();
    exp_q.push_back({8'd5, 17'd0});
    run_task(8'h11, 8'd5, 1'b1, lat);
    check("stall_latency", lat, 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("stall_valid_held", {result_valid_o, task_ready_o}, 2'b10);
    end
    check("stall_result", result_o, {8'h11, 2'd0, 2'd1});
    finish_result();
    check_writes("stall");
    check("stall_push_cnt", cnt_push - b_push, 1);
    check("stall_head_cnt", cnt_head - b_head, 1);

    // reset while a chain read is pending
    load_chain();
    mark();
    @(negedge clk_i);
    task_i = {8'hC3, 8'd5, 1'b1};
    task_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    task_valid_i = 1'b0;
    guard = 0;
    while (o_dbg_state != 3'd2 && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    check("abort_reached_walk", o_dbg_state, 3'd2);
    check("abort_read_pending", rd_en_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("abort_state", o_dbg_state, 3'd0);
    check("abort_strobes", {rd_en_o, wr_en_o, empty_addr_add_o, head_wr_en_o, result_valid_o}, 5'b0);
    rst_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check_writes("abort");
    check("abort_push", cnt_push - b_push, 0);
    check("abort_head", cnt_head - b_head, 0);
    check("abort_idle_after", o_dbg_state, 3'd0);

    // fresh task after the abort: head match on a multi-node chain
    mark();
    exp_q.push_back({8'd5, 17'd0});
    run_task(8'hA1, 8'd5, 1'b1, lat);
    check("post_latency", lat, 5);
    check("post_result", result_o, {8'hA1, 2'd0, 2'd1});
    finish_result();
    check_writes("post");
    check("post_head_val", last_head, {8'd9, 1'b1});
    check("post_push_addr", last_push, 8'd5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
